program_loader: RTL
===================

# program_loader

Boot-time instruction-memory writer for the single-cycle RISC-V datapath. It accepts a stream of 32-bit program words over a valid/ready interface and writes them sequentially into instruction memory from word address 0. It holds the core in reset while loading and for a fixed settle window afterwards, then releases the core to fetch from PC 0. It sits between the host/test stimulus and the instruction memory write port, beside the datapath's own fetch (read) port.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width (capacity 2^ADDR_WIDTH words)
- DATA_WIDTH, 32, instruction word width
- RELEASE_CYCLES, 2, cycles coreReset stays high after the last write (must be ≥1)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a load
- inValid  in  1  inData/inLast valid
- inReady  out  1  loader can accept a word
- inData  in  DATA_WIDTH  program word
- inLast  in  1  marks final word of program
- memWriteEnable  out  1  instruction-memory write strobe
- memAddress  out  ADDR_WIDTH  word address of write
- memData  out  DATA_WIDTH  word to write
- coreReset  out  1  reset to datapath, high while loading/settling
- busy  out  1  high in LOAD or RELEASE
- done  out  1  one-cycle pulse when core is released
- overflow  out  1  sticky: program exceeded memory capacity
- wordsLoaded  out  ADDR_WIDTH+1  count of words written in current/last load

## Operation
- States: IDLE, LOAD, RELEASE, RUN.
- Reset values: state IDLE; coreReset=1; inReady=0; memWriteEnable=0; memAddress=0; memData=0; busy=0; done=0; overflow=0; wordsLoaded=0.
- IDLE: coreReset=1. start → LOAD; write pointer and wordsLoaded cleared, overflow cleared.
- LOAD: inReady=1 (decoded from state). Handshake = inValid && inReady. Each handshake registers one write at the current pointer, then increments pointer and wordsLoaded. Cycles without inValid: no write, pointer holds.
- Handshake with inLast=1 → RELEASE.
- Handshake at pointer 2^ADDR_WIDTH−1 with inLast=0: word is written, overflow set, → RELEASE (pointer does not wrap; no further words accepted).
- RELEASE: inReady=0, coreReset=1, down-counter loaded with RELEASE_CYCLES−1; on reaching 0 → RUN.
- RUN: coreReset=0, busy=0; done=1 on the first RUN cycle only. start → LOAD (coreReset high again from next cycle); memory contents beyond new program are not cleared.
- start in LOAD or RELEASE is ignored.
- reset at any time, including mid-LOAD: immediate return to reset values; words already written remain in memory.

## Timing
- start sampled high at cycle n → LOAD, inReady=1, busy=1 at n+1.
- Handshake at cycle k → memWriteEnable=1 with memAddress/memData of that word during cycle k+1 only (latency 1). Back-to-back handshakes give back-to-back writes.
- Last (or overflow) handshake at k → RELEASE during k+1 … k+RELEASE_CYCLES; RUN at k+RELEASE_CYCLES+1 with coreReset=0 and done=1 that cycle.
- Final write (k+1) always precedes coreReset deassertion by ≥1 cycle.
- wordsLoaded updates in the same cycle as the corresponding memWriteEnable.

## Structure
- Shared package riscv_pkg: loader state enum (IDLE/LOAD/RELEASE/RUN), INSTR_WIDTH=32 constant.
- One sub-module: cycle_counter (loadable down-counter with zero flag) for the RELEASE window; everything else in program_loader.

## Test plan
- Start, 4 words 0x00500093, 0x00A00113, 0x002081B3, 0x00000013 (last on 4th), inValid continuous → writes at addresses 0–3 on consecutive cycles, wordsLoaded=4, coreReset low and done pulse exactly RELEASE_CYCLES+1 cycles after last handshake.
- Same program with inValid idle 2 cycles between words → no writes in gaps, addresses still 0–3, no duplicate writes.
- ADDR_WIDTH=2, 5 words without inLast → 4 writes (addresses 0–3), 5th not accepted (inReady=0), overflow=1, wordsLoaded=4, core released normally.
- Reset asserted after 2nd handshake → next cycle all outputs at reset values, coreReset=1, state IDLE; a new start loads from address 0.
- From RUN, start pulse with 1-word program 0xDEADBEEF → coreReset high next cycle, write at address 0, overflow cleared, done pulse again.
- start asserted during LOAD and RELEASE → no pointer reset, no state change.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the RISC-V boot loader
package riscv_pkg;

    localparam int INSTR_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } loader_state_e;

endpackage

// File: rtl/cycle_counter.sv
// rtl/cycle_counter.sv - loadable down-counter with zero flag
module cycle_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over decrement; the counter parks at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams program words into instruction memory, then releases the core
module program_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = INSTR_WIDTH,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [DATA_WIDTH-1:0] inData,
    input  logic                  inLast,
    output logic                  memWriteEnable,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memData,
    output logic                  coreReset,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   wordsLoaded
);

    localparam int CNT_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX  = '1;

    loader_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic                  ovf_q, ovf_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;

    logic             handshake;
    logic             load_end;
    logic             restart;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_value;

    assign handshake = inValid && inReady;
    // The final slot ends the load even without inLast, so the pointer never wraps.
    assign load_end  = handshake && (inLast || (ptr_q == PTR_MAX));
    assign restart   = start && ((state_q == ST_IDLE) || (state_q == ST_RUN));

    cycle_counter #(
        .WIDTH (CNT_W)
    ) u_release_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (load_end),
        .load_value (CNT_LOAD),
        .enable     (state_q == ST_RELEASE),
        .count      (cnt_value),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            words_q <= '0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            words_q <= words_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start)    state_d = ST_LOAD;
            ST_LOAD:    if (load_end) state_d = ST_RELEASE;
            ST_RELEASE: if (cnt_zero) state_d = ST_RUN;
            ST_RUN:     if (start)    state_d = ST_LOAD;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        words_d = words_q;
        ovf_d   = ovf_q;
        we_d    = handshake;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = (state_q == ST_RELEASE) && cnt_zero;
        if (restart) begin
            ptr_d   = '0;
            words_d = '0;
            ovf_d   = 1'b0;
        end else if (handshake) begin
            addr_d  = ptr_q;
            data_d  = inData;
            words_d = words_q + (ADDR_WIDTH+1)'(1);
            if (ptr_q != PTR_MAX) begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
            end else if (!inLast) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        inReady   = (state_q == ST_LOAD);
        busy      = (state_q == ST_LOAD) || (state_q == ST_RELEASE);
        coreReset = (state_q != ST_RUN);
    end

    assign memWriteEnable = we_q;
    assign memAddress     = addr_q;
    assign memData        = data_q;
    assign done           = done_q;
    assign overflow       = ovf_q;
    assign wordsLoaded    = words_q;

endmodule
